mm_dispatch: RTL and testbench

Sequencing controller for the matrix-multiply unit (`mm_top`). It accepts 128-bit MM instructions from the instruction fetch stage over a valid/ready handshake and validates the buffer-select fields. It holds each instruction stable on `instruction_to_mm` for the whole execution, pulses `valid_to_mm`, and waits for `done_from_mm`, with timeout supervision and performance counters.

---
 rtl/mm_pkg.sv | 41 ++++
 rtl/mm_instr_check.sv | 29 ++
 rtl/mm_dispatch.sv | 141 ++++++++++++++
 tb/tb_mm_dispatch.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the matrix-multiply sequencing path.
//   - instruction field positions (selects, N, flags, start addresses)
//   - buffer select encodings
//   - dispatcher state enum
//   - one-hot helper used by the instruction checker
package mm_pkg;

  localparam int INSTR_W = 128;

  localparam int IN_SEL_LSB   = 1;
  localparam int IN_SEL_MSB   = 4;
  localparam int RELU_BIT     = 5;
  localparam int ACC_BIT      = 6;
  localparam int OUT_SEL_LSB  = 7;
  localparam int OUT_SEL_MSB  = 10;
  localparam int BIAS_BIT     = 11;
  localparam int SRC_ADDR_LSB = 12;
  localparam int SRC_ADDR_MSB = 43;
  localparam int DST_ADDR_LSB = 44;
  localparam int DST_ADDR_MSB = 75;
  localparam int N_LSB        = 110;
  localparam int N_MSB        = 127;

  localparam logic [3:0] SEL_1A = 4'b0001;
  localparam logic [3:0] SEL_1B = 4'b0010;
  localparam logic [3:0] SEL_2A = 4'b0100;
  localparam logic [3:0] SEL_2B = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } mm_disp_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mm_instr_check.sv
// mm_instr_check: combinational legality check of a 128-bit MM instruction.
//   instr_i  : instruction word
//   legal    : selects are valid (input one-hot, output is a bank-2 buffer,
//              source and destination differ)
//   n_zero   : N field is zero (legal no-op)
module mm_instr_check
  import mm_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic               legal,
  output logic               n_zero
);

  logic [3:0] in_sel;
  logic [3:0] out_sel;
  logic       out_ok;
  logic       unused_bits;

  assign in_sel  = instr_i[IN_SEL_MSB:IN_SEL_LSB];
  assign out_sel = instr_i[OUT_SEL_MSB:OUT_SEL_LSB];
  assign out_ok  = (out_sel == SEL_2A) || (out_sel == SEL_2B);

  assign legal  = is_onehot4(in_sel) && out_ok && (in_sel != out_sel);
  assign n_zero = (instr_i[N_MSB:N_LSB] == '0);

  // Remaining fields are consumed by mm_top, not checked here.
  assign unused_bits = ^instr_i;

endmodule

// File: rtl/mm_dispatch.sv
// mm_dispatch: accepts MM instructions from fetch, validates them, issues
// them to mm_top and waits for completion under watchdog supervision.
//   ap_clk / areset (async, active-low)
//   instr_in, instr_in_valid, instr_in_ready : fetch handshake
//   instruction_to_mm, valid_to_mm, done_from_mm : mm_top interface
//   done_out : completion pulse to the top controller
//   timeout_cycles : watchdog limit (0 = disabled)
//   clear_err, err_illegal, err_timeout : sticky error flags
//   busy, instr_count, busy_cycles : status and saturating counters
//
// state  | meaning
// IDLE   | ready for an instruction, latch on valid
// CHECK  | validate latched instruction
// ISSUE  | start pulse to mm_top, clear watchdog
// WAIT   | wait for done_from_mm or watchdog expiry
// DONE   | completion pulse, count instruction
module mm_dispatch
  import mm_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TO_W  = 24
) (
  input  logic               ap_clk,
  input  logic               areset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_in_valid,
  output logic               instr_in_ready,
  output logic [INSTR_W-1:0] instruction_to_mm,
  output logic               valid_to_mm,
  input  logic               done_from_mm,
  output logic               done_out,
  input  logic [TO_W-1:0]    timeout_cycles,
  input  logic               clear_err,
  output logic               err_illegal,
  output logic               err_timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   busy_cycles
);

  mm_disp_state_t     state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               err_ill_q, err_ill_d;
  logic               err_to_q, err_to_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic               legal, n_zero;
  logic               set_ill, set_to;

  mm_instr_check u_check (
    .instr_i (instr_q),
    .legal   (legal),
    .n_zero  (n_zero)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    wd_d    = wd_q;
    set_ill = 1'b0;
    set_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_in_valid) begin
          instr_d = instr_in;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!legal) begin
          set_ill = 1'b1;
          state_d = ST_DONE;
        end else if (n_zero) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a coincident watchdog expiry
        if (done_from_mm) begin
          state_d = ST_DONE;
        end else if ((timeout_cycles != '0) &&
                     (wd_q == timeout_cycles - TO_W'(1))) begin
          set_to  = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // a set in the same cycle as clear_err wins
    err_ill_d = set_ill | (err_ill_q & ~clear_err);
    err_to_d  = set_to  | (err_to_q  & ~clear_err);
    icnt_d    = icnt_q;
    if ((state_q == ST_DONE) && (icnt_q != '1)) icnt_d = icnt_q + CNT_W'(1);
    bcnt_d    = bcnt_q;
    if ((state_q != ST_IDLE) && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
  end

  always_ff @(posedge ap_clk or negedge areset) begin
    if (!areset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      wd_q      <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
      icnt_q    <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      wd_q      <= wd_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
      icnt_q    <= icnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign instr_in_ready    = (state_q == ST_IDLE);
  assign valid_to_mm       = (state_q == ST_ISSUE);
  assign done_out          = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);
  assign instruction_to_mm = instr_q;
  assign err_illegal       = err_ill_q;
  assign err_timeout       = err_to_q;
  assign instr_count       = icnt_q;
  assign busy_cycles       = bcnt_q;

endmodule

// File: tb/tb_mm_dispatch.sv
module tb_mm_dispatch;

  logic         ap_clk = 1'b0;
  logic         areset;
  logic [127:0] instr_in;
  logic         instr_in_valid;
  logic         instr_in_ready;
  logic [127:0] instruction_to_mm;
  logic         valid_to_mm;
  logic         done_from_mm;
  logic         done_out;
  logic [7:0]   timeout_cycles;
  logic         clear_err;
  logic         err_illegal;
  logic         err_timeout;
  logic         busy;
  logic [7:0]   instr_count;
  logic [7:0]   busy_cycles;

  mm_dispatch #(.CNT_W(8), .TO_W(8)) dut (
    .ap_clk            (ap_clk),
    .areset            (areset),
    .instr_in          (instr_in),
    .instr_in_valid    (instr_in_valid),
    .instr_in_ready    (instr_in_ready),
    .instruction_to_mm (instruction_to_mm),
    .valid_to_mm       (valid_to_mm),
    .done_from_mm      (done_from_mm),
    .done_out          (done_out),
    .timeout_cycles    (timeout_cycles),
    .clear_err         (clear_err),
    .err_illegal       (err_illegal),
    .err_timeout       (err_timeout),
    .busy              (busy),
    .instr_count       (instr_count),
    .busy_cycles       (busy_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [127:0] instr;
    logic         ill;
    logic         to;
    int           iss;
    logic [7:0]   cnt;
  } sb_t;

  sb_t        sb[$];
  int         checks = 0;
  int         failures = 0;
  int         vcount = 0;
  logic       post_pend = 1'b0;
  logic [7:0] post_cnt = 8'd0;
  logic [7:0] exp_cnt = 8'd0;
  logic       ill_sticky = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [3:0] in_s, input logic [3:0] out_s,
                                      input logic [17:0] n, input logic [31:0] tag);
    logic [127:0] r;
    r          = '0;
    r[4:1]     = in_s;
    r[10:7]    = out_s;
    r[75:44]   = tag;
    r[43:12]   = ~tag;
    r[5]       = tag[0];
    r[127:110] = n;
    return r;
  endfunction

  function automatic logic legal_model(input logic [127:0] ins);
    logic [3:0] i_s, o_s;
    i_s = ins[4:1];
    o_s = ins[10:7];
    return ($countones(i_s) == 1) && ((o_s == 4'b0100) || (o_s == 4'b1000)) && (i_s != o_s);
  endfunction

  task automatic push(input logic [127:0] ins, input logic ill_now, input logic to, input int iss);
    sb_t e;
    ill_sticky = ill_sticky | ill_now;
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    e.instr = ins;
    e.ill   = ill_sticky;
    e.to    = to;
    e.iss   = iss;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample 1ns after the edge, and retire scoreboard
  // entries whenever the DUT reports completion.
  task automatic tick();
    sb_t e;
    @(posedge ap_clk);
    #1;
    if (post_pend) begin
      chk8("instr_count", instr_count, post_cnt);
      post_pend = 1'b0;
    end
    if (valid_to_mm) vcount++;
    if (done_out) begin
      chk1("done_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chkw("instr_at_done", instruction_to_mm, e.instr);
        chk1("err_illegal_at_done", err_illegal, e.ill);
        chk1("err_timeout_at_done", err_timeout, e.to);
        chki("valid_pulses", vcount, e.iss);
        vcount    = 0;
        post_pend = 1'b1;
        post_cnt  = e.cnt;
      end
    end
  endtask

  // Instruction that never issues (illegal or N=0): done in cycle 2, ready in cycle 3.
  task automatic run_quick(input logic [127:0] ins, input logic hold, input logic [127:0] junk);
    push(ins, !legal_model(ins), 1'b0, 0);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    chk1("quick_c1_ready", instr_in_ready, 1'b0);
    chk1("quick_c1_valid_mm", valid_to_mm, 1'b0);
    if (!hold) instr_in_valid = 1'b0;
    instr_in = junk;
    tick();
    chk1("quick_c2_done", done_out, 1'b1);
    chk1("quick_c2_valid_mm", valid_to_mm, 1'b0);
    tick();
    chk1("quick_c3_ready", instr_in_ready, 1'b1);
  endtask

  initial begin
    logic [127:0] ins;
    areset         = 1'b0;
    instr_in       = '0;
    instr_in_valid = 1'b0;
    done_from_mm   = 1'b0;
    timeout_cycles = 8'd0;
    clear_err      = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk1("rst_ready", instr_in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid_mm", valid_to_mm, 1'b0);
    chk1("rst_done", done_out, 1'b0);
    chkw("rst_instr", instruction_to_mm, 128'd0);
    chk8("rst_icnt", instr_count, 8'd0);
    chk8("rst_bcnt", busy_cycles, 8'd0);
    areset = 1'b1;

    // Legal instruction, done 10 cycles after the start pulse
    ins = mk(4'b0001, 4'b0100, 18'd16, 32'hCAFE_0001);
    push(ins, 1'b0, 1'b0, 1);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    chk1("t1_c1_ready", instr_in_ready, 1'b0);
    chk1("t1_c1_valid_mm", valid_to_mm, 1'b0);
    chkw("t1_c1_instr", instruction_to_mm, ins);
    instr_in_valid = 1'b0;
    instr_in       = ~ins;
    tick();
    chk1("t1_c2_valid_mm", valid_to_mm, 1'b1);
    tick();
    chk1("t1_c3_valid_mm", valid_to_mm, 1'b0);
    for (int i = 4; i <= 12; i++) begin
      tick();
      chk1("t1_wait_done", done_out, 1'b0);
      chkw("t1_wait_instr", instruction_to_mm, ins);
    end
    done_from_mm = 1'b1;
    tick();
    done_from_mm = 1'b0;
    chk1("t1_done", done_out, 1'b1);
    tick();
    chk1("t1_ready", instr_in_ready, 1'b1);
    chk8("t1_busy_cycles", busy_cycles, 8'd13);
    chkw("t1_instr_hold", instruction_to_mm, ins);

    // Same bank-2 buffer as source and destination
    run_quick(mk(4'b0100, 4'b0100, 18'd16, 32'h2), 1'b0, '0);
    chk1("t2_sticky", err_illegal, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err  = 1'b0;
    ill_sticky = 1'b0;
    chk1("t2_cleared", err_illegal, 1'b0);

    // Non-one-hot input, bad output select, then legal N=0
    run_quick(mk(4'b0011, 4'b1000, 18'd16, 32'h3), 1'b0, '0);
    run_quick(mk(4'b0001, 4'b0010, 18'd16, 32'h4), 1'b0, '0);
    clear_err = 1'b1;
    tick();
    clear_err  = 1'b0;
    ill_sticky = 1'b0;
    run_quick(mk(4'b0010, 4'b1000, 18'd0, 32'h5), 1'b0, '0);
    chk1("t3_noop_no_err", err_illegal, 1'b0);

    // Watchdog T=5
    timeout_cycles = 8'd5;
    ins = mk(4'b0001, 4'b1000, 18'd7, 32'h6);
    push(ins, 1'b0, 1'b1, 1);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    instr_in_valid = 1'b0;
    tick();
    chk1("t4_issue", valid_to_mm, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t4_wait_done", done_out, 1'b0);
      chk1("t4_wait_err", err_timeout, 1'b0);
    end
    tick();
    chk1("t4_done", done_out, 1'b1);
    chk1("t4_err", err_timeout, 1'b1);
    tick();
    chk1("t4_ready", instr_in_ready, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk1("t4_cleared", err_timeout, 1'b0);

    // Watchdog disabled: waits indefinitely
    timeout_cycles = 8'd0;
    ins = mk(4'b0010, 4'b0100, 18'd9, 32'h7);
    push(ins, 1'b0, 1'b0, 1);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    instr_in_valid = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk1("t4b_wait_done", done_out, 1'b0);
      chk1("t4b_wait_busy", busy, 1'b1);
    end
    chk1("t4b_no_err", err_timeout, 1'b0);
    done_from_mm = 1'b1;
    tick();
    done_from_mm = 1'b0;
    chk1("t4b_done", done_out, 1'b1);
    tick();

    // done in IDLE ignored
    done_from_mm = 1'b1;
    tick();
    done_from_mm = 1'b0;
    chk1("t5_idle_done", done_out, 1'b0);
    chk1("t5_idle_busy", busy, 1'b0);

    // done in CHECK/ISSUE ignored, then done coinciding with timeout (T=3)
    timeout_cycles = 8'd3;
    ins = mk(4'b1000, 4'b0100, 18'd3, 32'h8);
    push(ins, 1'b0, 1'b0, 1);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    instr_in_valid = 1'b0;
    done_from_mm   = 1'b1;
    tick();
    chk1("t5_issue_valid", valid_to_mm, 1'b1);
    tick();
    done_from_mm = 1'b0;
    chk1("t5_c3_done", done_out, 1'b0);
    tick();
    chk1("t5_c4_done", done_out, 1'b0);
    tick();
    chk1("t5_c5_done", done_out, 1'b0);
    done_from_mm = 1'b1;
    tick();
    done_from_mm = 1'b0;
    chk1("t5_coincide_done", done_out, 1'b1);
    chk1("t5_coincide_no_err", err_timeout, 1'b0);
    tick();

    // Reset during WAIT with a sticky error set
    run_quick(mk(4'b0100, 4'b0100, 18'd1, 32'h9), 1'b0, '0);
    timeout_cycles = 8'd0;
    ins = mk(4'b0001, 4'b0100, 18'd2, 32'hA);
    push(ins, 1'b0, 1'b0, 1);
    instr_in       = ins;
    instr_in_valid = 1'b1;
    tick();
    instr_in_valid = 1'b0;
    repeat (3) tick();
    chk1("t6_pre_busy", busy, 1'b1);
    areset = 1'b0;
    #1;
    chk1("t6_ready", instr_in_ready, 1'b1);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_valid_mm", valid_to_mm, 1'b0);
    chk1("t6_done", done_out, 1'b0);
    chk1("t6_err_ill", err_illegal, 1'b0);
    chk1("t6_err_to", err_timeout, 1'b0);
    chk8("t6_icnt", instr_count, 8'd0);
    chk8("t6_bcnt", busy_cycles, 8'd0);
    chkw("t6_instr", instruction_to_mm, 128'd0);
    sb.delete();
    vcount     = 0;
    post_pend  = 1'b0;
    exp_cnt    = 8'd0;
    ill_sticky = 1'b0;
    #1;
    areset = 1'b1;

    // Back-to-back with valid held high; junk offered while busy must not be taken
    for (int i = 0; i < 260; i++) begin
      run_quick(mk(4'b0010, 4'b1000, 18'd0, 32'(i)), 1'b1,
                mk(4'b0001, 4'b0100, 18'd5, 32'hDEAD_0000 + 32'(i)));
    end
    instr_in_valid = 1'b0;
    tick();
    chk8("sat_icnt", instr_count, 8'hFF);
    chk8("sat_bcnt", busy_cycles, 8'hFF);
    chk1("sat_idle", busy, 1'b0);
    chki("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
